// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disp_pkg
// Description : Shared glyph patterns, output polarities and sizing helper
//               for the multiplexed 7-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Active-low segment patterns, bit6 = a ... bit0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic ANODE_ON  = 1'b0;
    localparam logic ANODE_OFF = 1'b1;
    localparam logic DP_ON     = 1'b0;
    localparam logic DP_OFF    = 1'b1;

    // Width needed to hold 0..n-1, never less than one bit
    function automatic int clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/seg7_glyph.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph
// Description : Combinational nibble to active-low segment lookup.
//               DISP_HEX_FULL_EN selects the full A-F hex glyph set.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
`ifdef DISP_HEX_FULL_EN
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
`else
            // Legacy decoder only ever defined E among the letters
            4'hE: seg_o = SEG_E;
`endif
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule : seg7_glyph
`default_nettype wire

// File: rtl/disp_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_mux
// Description : Time-multiplexed common-anode 7-segment driver with load
//               handshake, tear-free frame commit, leading-zero blanking and
//               decimal points. Honours DISP_HEX_FULL_EN via seg7_glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic                  blank_zeros,
    output logic [DIGITS-1:0]     anodes,
    output logic [6:0]            segmentos,
    output logic                  dp
);

    localparam int IW = clog2(DIGITS);
    localparam int CW = clog2(SCAN_DIV);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]    active_val_q, active_val_d;
    logic [DIGITS-1:0]      active_dp_q, active_dp_d;
    logic                   pending_q, pending_d;
    logic                   ready_q, ready_d;
    logic [DIGITS-1:0]      anodes_q, anodes_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;

    logic                   w_tc;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_commit;
    logic [3:0]             w_nibble;
    logic                   w_dp_sel;
    logic [DIGITS-1:0]      w_lead_zero;
    logic                   w_zeros_above;
    logic                   w_blank;
    logic [6:0]             w_glyph;

    assign w_tc     = (cnt_q == CW'(SCAN_DIV - 1));
    assign w_last   = (idx_q == IW'(DIGITS - 1));
    assign w_accept = load_valid & ready_q;
    // Frozen scan has no frame boundary to wait for, so commit straight away
    assign w_commit = pending_q & (~enable | (w_tc & w_last));

    always_comb begin
        w_nibble      = 4'h0;
        w_dp_sel      = 1'b0;
        w_lead_zero   = '0;
        w_zeros_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zeros_above  = w_zeros_above & (active_val_q[i*4 +: 4] == 4'h0);
            w_lead_zero[i] = w_zeros_above;
            if (idx_q == IW'(i)) begin
                w_nibble = active_val_q[i*4 +: 4];
                w_dp_sel = active_dp_q[i];
            end
        end
    end

    assign w_blank = blank_zeros & (idx_q != '0) & w_lead_zero[idx_q];

    seg7_glyph u_glyph (
        .nibble_i (w_nibble),
        .seg_o    (w_glyph)
    );

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        active_val_d = active_val_q;
        active_dp_d  = active_dp_q;
        pending_d    = pending_q;
        anodes_d     = {DIGITS{ANODE_OFF}};
        seg_d        = SEG_BLANK;
        dp_d         = DP_OFF;

        if (enable) begin
            if (w_tc) begin
                cnt_d = '0;
                idx_d = w_last ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            anodes_d = ~(DIGITS'(1) << idx_q);
            if (!w_blank) begin
                seg_d = w_glyph;
                dp_d  = w_dp_sel ? DP_ON : DP_OFF;
            end
        end

        if (w_accept) begin
            shadow_val_d = load_value;
            shadow_dp_d  = load_dp;
            pending_d    = 1'b1;
        end
        if (w_commit) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
            pending_d    = 1'b0;
        end
        ready_d = ~pending_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            ready_q      <= 1'b1;
            anodes_q     <= {DIGITS{ANODE_OFF}};
            seg_q        <= SEG_BLANK;
            dp_q         <= DP_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            active_val_q <= active_val_d;
            active_dp_q  <= active_dp_d;
            pending_q    <= pending_d;
            ready_q      <= ready_d;
            anodes_q     <= anodes_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign load_ready = ready_q;
    assign anodes     = anodes_q;
    assign segmentos  = seg_q;
    assign dp         = dp_q;

endmodule : disp_scan_mux
`default_nettype wire

// File: tb/tb_disp_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_scan_mux
// Description : Randomized and directed bench for disp_scan_mux (4 digits,
//               4 clocks per slot) against a behavioural display model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan_mux;

    localparam int ND = 4;
    localparam int SD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = '0;
    logic [3:0]  load_dp = '0;
    logic        blank_zeros = 1'b0;
    logic [3:0]  anodes;
    logic [6:0]  segmentos;
    logic        dp;

    int checks = 0;
    int errors = 0;

    disp_scan_mux #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .load_dp     (load_dp),
        .blank_zeros (blank_zeros),
        .anodes      (anodes),
        .segmentos   (segmentos),
        .dp          (dp)
    );

    always #5 clock = ~clock;

    // Model: time position inside the scan, displayed and queued frames
    logic [6:0]  glyph_tab [16];
    int          m_cnt, m_idx;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_actdp, m_shdp;
    logic        m_pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_act = '0; m_sh = '0;
        m_actdp = '0; m_shdp = '0; m_pend = 1'b0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_rdy = 1'b1;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".anodes"}, 32'(anodes), 32'(e_an));
        chk({tag, ".seg"},    32'(segmentos), 32'(e_seg));
        chk({tag, ".dp"},     32'(dp), 32'(e_dp));
        chk({tag, ".ready"},  32'(load_ready), 32'(e_rdy));
    endtask

    task automatic step(input logic en, input logic lv, input logic [15:0] v,
                        input logic [3:0] d, input logic bz, input string tag);
        logic [15:0] upper;
        logic        blk, acc, com;
        enable = en; load_valid = lv; load_value = v; load_dp = d; blank_zeros = bz;
        @(posedge clock);
        if (!en) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            upper = m_act >> (4 * m_idx);
            blk   = bz && (m_idx != 0) && (upper == 16'h0);
            e_an  = ~(4'b0001 << m_idx);
            e_seg = blk ? 7'h7F : glyph_tab[upper[3:0]];
            e_dp  = blk ? 1'b1 : ~m_actdp[m_idx];
        end
        acc = lv && !m_pend;
        com = m_pend && (!en || (m_cnt == SD - 1 && m_idx == ND - 1));
        if (acc) begin m_sh = v; m_shdp = d; m_pend = 1'b1; end
        if (com) begin m_act = m_sh; m_actdp = m_shdp; m_pend = 1'b0; end
        if (en) begin
            m_cnt = (m_cnt + 1) % SD;
            if (m_cnt == 0) m_idx = (m_idx + 1) % ND;
        end
        e_rdy = !m_pend;
        #1;
        compare_all(tag);
    endtask

    task automatic run(input int n, input logic en, input logic bz, input string tag);
        for (int i = 0; i < n; i++) step(en, 1'b0, 16'h0, 4'h0, bz, tag);
    endtask

    initial begin
        logic [15:0] masks [4];
        masks[0] = 16'hFFFF; masks[1] = 16'h00FF; masks[2] = 16'h000F; masks[3] = 16'h0F0F;
        glyph_tab[0]  = 7'b0000001; glyph_tab[1]  = 7'b1001111;
        glyph_tab[2]  = 7'b0010010; glyph_tab[3]  = 7'b0000110;
        glyph_tab[4]  = 7'b1001100; glyph_tab[5]  = 7'b0100100;
        glyph_tab[6]  = 7'b0100000; glyph_tab[7]  = 7'b0001111;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0000100;
`ifdef DISP_HEX_FULL_EN
        glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b1100000;
        glyph_tab[12] = 7'b0110001; glyph_tab[13] = 7'b1000010;
        glyph_tab[14] = 7'b0110000; glyph_tab[15] = 7'b0111000;
`else
        glyph_tab[10] = 7'b1111111; glyph_tab[11] = 7'b1111111;
        glyph_tab[12] = 7'b1111111; glyph_tab[13] = 7'b1111111;
        glyph_tab[14] = 7'b0110000; glyph_tab[15] = 7'b1111111;
`endif
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        compare_all("reset");
        reset = 1'b0;

        step(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0, "load1234");
        run(40, 1'b1, 1'b0, "scan1234");

        step(1'b1, 1'b1, 16'h5678, 4'h0, 1'b0, "load5678");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'h9999, 4'h0, 1'b0, "hold9999");
        run(30, 1'b1, 1'b0, "scan5678");

        step(1'b1, 1'b1, 16'h0070, 4'h0, 1'b1, "load0070");
        run(30, 1'b1, 1'b1, "blank0070");
        step(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1, "load0000");
        run(30, 1'b1, 1'b1, "blank0000");

        step(1'b1, 1'b1, 16'hEABF, 4'b0001, 1'b1, "loadEABF");
        run(24, 1'b1, 1'b1, "glyphEABF");

        run(5, 1'b1, 1'b0, "preen");
        step(1'b1, 1'b1, 16'h4321, 4'b1010, 1'b0, "load4321");
        run(10, 1'b0, 1'b0, "disabled");
        run(20, 1'b1, 1'b0, "reenabled");

        // Asynchronous reset with a frame still pending
        run(3, 1'b1, 1'b0, "prerst");
        step(1'b1, 1'b1, 16'h8888, 4'hF, 1'b0, "loadprerst");
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all("asyncrst");
        @(posedge clock);
        #1 reset = 1'b0;
        run(20, 1'b1, 1'b0, "postrst");

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                 16'($urandom) & masks[$urandom_range(0, 3)], 4'($urandom),
                 1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_disp_scan_mux
`default_nettype wire
